// File: rtl/anneal_scheduler.sv
// anneal_scheduler: sequences a one-hot update enable across N_PBITS p-bits,
// counts completed sweeps and raises the inverse temperature (beta) on a
// programmable sweep interval, saturating at beta_max.
// Optional build macro: ANNEAL_SAMPLE_EN adds output sample_valid, a one-cycle
// pulse on the cycle after every completed sweep.
module anneal_scheduler #(
    parameter int N_PBITS = 5,
    parameter int SWEEP_W = 16,
    parameter int BETA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [SWEEP_W-1:0] sweeps_per_step,
    input  logic [BETA_W-1:0]  beta_start,
    input  logic [BETA_W-1:0]  beta_step,
    input  logic [BETA_W-1:0]  beta_max,
    input  logic               hold,
    output logic [N_PBITS-1:0] update_out,
    output logic [BETA_W-1:0]  beta,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               busy,
    output logic               done
`ifdef ANNEAL_SAMPLE_EN
    ,
    output logic               sample_valid
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Position of the first p-bit in the rotation.
    localparam logic [N_PBITS-1:0] POS_FIRST = N_PBITS'(1);

    // FSM and datapath state.
    logic [1:0]         state_reg, state_next;
    logic [N_PBITS-1:0] pos_reg, pos_next;
    logic [BETA_W-1:0]  beta_reg, beta_next;
    logic [SWEEP_W-1:0] sweep_count_reg, sweep_count_next;
    logic [SWEEP_W-1:0] step_cnt_reg, step_cnt_next;

    // Run configuration captured when a start is accepted.
    logic [SWEEP_W-1:0] n_sweeps_reg, n_sweeps_next;
    logic [SWEEP_W-1:0] sweeps_per_step_reg, sweeps_per_step_next;
    logic [BETA_W-1:0]  beta_step_reg, beta_step_next;
    logic [BETA_W-1:0]  beta_max_reg, beta_max_next;

    // Helper terms for the sequencing decisions.
    logic [N_PBITS-1:0] pos_rot;
    logic               advance;
    logic               sweep_end;
    logic [SWEEP_W-1:0] sweep_count_inc;
    logic [SWEEP_W-1:0] step_cnt_inc;
    logic [BETA_W:0]    beta_sum;
    logic [BETA_W-1:0]  beta_sat;

`ifdef ANNEAL_SAMPLE_EN
    logic sample_valid_reg, sample_valid_next;
`endif

    // One-hot rotation: bit k moves to bit k+1, the top bit wraps to bit 0.
    generate
        for (genvar gi = 0; gi < N_PBITS; gi++) begin : g_rot
            assign pos_rot[gi] = pos_reg[(gi + N_PBITS - 1) % N_PBITS];
        end
    endgenerate

    assign advance         = (state_reg == ST_RUN) && !hold;
    assign sweep_end       = advance && pos_reg[N_PBITS-1];
    assign sweep_count_inc = sweep_count_reg + SWEEP_W'(1);
    assign step_cnt_inc    = step_cnt_reg + SWEEP_W'(1);

    // The extra sum bit keeps a near-max beta from wrapping before the clamp.
    assign beta_sum = {1'b0, beta_reg} + {1'b0, beta_step_reg};
    assign beta_sat = (beta_sum > {1'b0, beta_max_reg}) ? beta_max_reg
                                                         : beta_sum[BETA_W-1:0];

    // Next-state logic for the FSM, position, counters and beta schedule.
    always_comb begin
        state_next           = state_reg;
        pos_next             = pos_reg;
        beta_next            = beta_reg;
        sweep_count_next     = sweep_count_reg;
        step_cnt_next        = step_cnt_reg;
        n_sweeps_next        = n_sweeps_reg;
        sweeps_per_step_next = sweeps_per_step_reg;
        beta_step_next       = beta_step_reg;
        beta_max_next        = beta_max_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    n_sweeps_next        = n_sweeps;
                    sweeps_per_step_next = sweeps_per_step;
                    beta_step_next       = beta_step;
                    beta_max_next        = beta_max;
                    sweep_count_next     = '0;
                    step_cnt_next        = '0;
                    beta_next            = beta_start;
                    pos_next             = POS_FIRST;
                    state_next           = (n_sweeps == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (advance) begin
                    pos_next = pos_rot;
                end
                if (sweep_end) begin
                    sweep_count_next = sweep_count_inc;
                    // A zero interval disables beta stepping entirely.
                    if (sweeps_per_step_reg != '0) begin
                        if (step_cnt_inc == sweeps_per_step_reg) begin
                            step_cnt_next = '0;
                            beta_next     = beta_sat;
                        end else begin
                            step_cnt_next = step_cnt_inc;
                        end
                    end
                    // The final sweep still takes its beta step on the same edge.
                    if (sweep_count_inc == n_sweeps_reg) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef ANNEAL_SAMPLE_EN
    // Sample strobe trails each sweep completion by one cycle.
    always_comb begin
        sample_valid_next = sweep_end;
    end
`endif

    // State registers with synchronous reset; reset overrides start and hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            pos_reg             <= POS_FIRST;
            beta_reg            <= '0;
            sweep_count_reg     <= '0;
            step_cnt_reg        <= '0;
            n_sweeps_reg        <= '0;
            sweeps_per_step_reg <= '0;
            beta_step_reg       <= '0;
            beta_max_reg        <= '0;
        end else begin
            state_reg           <= state_next;
            pos_reg             <= pos_next;
            beta_reg            <= beta_next;
            sweep_count_reg     <= sweep_count_next;
            step_cnt_reg        <= step_cnt_next;
            n_sweeps_reg        <= n_sweeps_next;
            sweeps_per_step_reg <= sweeps_per_step_next;
            beta_step_reg       <= beta_step_next;
            beta_max_reg        <= beta_max_next;
        end
    end

`ifdef ANNEAL_SAMPLE_EN
    // Sample strobe register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_valid_reg <= 1'b0;
        end else begin
            sample_valid_reg <= sample_valid_next;
        end
    end

    assign sample_valid = sample_valid_reg;
`endif

    // Update enable is gated combinationally so hold blanks it immediately.
    assign update_out  = advance ? pos_reg : '0;
    assign beta        = beta_reg;
    assign sweep_count = sweep_count_reg;
    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_DONE);

endmodule

// File: doc/anneal_scheduler.md
ANNEAL_SCHEDULER -- requirements
Module: anneal_scheduler

Interface
REQ-001 Parameter N_PBITS, default 5: number of p-bits sequenced.
REQ-002 Parameter SWEEP_W, default 16: width of sweep counts.
REQ-003 Parameter BETA_W, default 8: width of inverse-temperature (beta) value, unsigned.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a new anneal run; sampled in IDLE only.
REQ-007 n_sweeps  input  SWEEP_W  total sweeps for the run; latched on start acceptance.
REQ-008 sweeps_per_step  input  SWEEP_W  sweeps between beta increments; latched on start; 0 = never step.
REQ-009 beta_start, beta_step, beta_max  input  BETA_W each  beta schedule; latched on start.
REQ-010 hold  input  1  stall; freezes sequencing while high in RUN.
REQ-011 update_out  output  N_PBITS  one-hot p-bit update enable, or all-zero.
REQ-012 beta  output  BETA_W  current inverse temperature driven to the p-bit array.
REQ-013 sweep_count  output  SWEEP_W  completed sweeps in current/last run.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse at run completion.

Function
REQ-016 FSM states IDLE, RUN, DONE; encoding is implementation-defined.
REQ-017 IDLE with start=1: latch config, sweep_count<=0, internal step counter<=0, beta<=beta_start, position<=bit 0; next state RUN, or DONE if n_sweeps=0.
REQ-018 IDLE with start=0: remain IDLE; beta and sweep_count hold their values.
REQ-019 start in RUN or DONE shall be ignored (not queued).
REQ-020 update_out shall equal the one-hot position when state=RUN and hold=0, else all-zero (combinational gating of registered position).
REQ-021 RUN, hold=0: position rotates bit k -> bit k+1 each cycle; bit N_PBITS-1 wraps to bit 0.
REQ-022 RUN, hold=1: position, counters, beta unchanged; busy stays high.
REQ-023 Sweep completes on a RUN cycle with hold=0 and position at bit N_PBITS-1: sweep_count increments by 1 on that edge.
REQ-024 On sweep completion with sweeps_per_step!=0: step counter increments; when it reaches sweeps_per_step, it clears and beta<=min(beta+beta_step, beta_max), computed without overflow (BETA_W+1 bit sum).
REQ-025 On sweep completion where new sweep_count equals latched n_sweeps: next state DONE, no beta step suppression (REQ-024 still applies on that edge).
REQ-026 DONE: done=1, update_out=0, busy=0 for exactly one cycle; next state IDLE.
REQ-027 Latency: start accepted at edge 0, n_sweeps=S>0: exactly S*N_PBITS update cycles (plus hold cycles); done high in the cycle after the last update.
REQ-028 beta and sweep_count shall retain final run values in IDLE until the next accepted start.
REQ-029 beta_start > beta_max: beta starts at beta_start and only saturating steps to beta_max apply thereafter (no step increases it).

Reset
REQ-030 reset=1 at any edge, including mid-RUN or during hold: state<=IDLE, position<=bit 0, update_out=0, beta=0, sweep_count=0, step counter=0, busy=0, done=0.
REQ-031 reset has priority over start and hold.

Configuration
REQ-032 Macro ANNEAL_SAMPLE_EN: when defined, add output sample_valid (1 bit), pulsed high for one cycle on the cycle after each sweep completion (including the last), reset value 0, for capturing p-bit states.
REQ-033 Without ANNEAL_SAMPLE_EN, port sample_valid shall not exist; all other behaviour identical.

Verification
REQ-034 N_PBITS=5, n_sweeps=2, sweeps_per_step=0, beta_start=10: update_out 00001,00010,...,10000 twice (10 cycles), done one cycle later, sweep_count=2, beta=10.
REQ-035 n_sweeps=4, sweeps_per_step=1, beta_start=250, beta_step=4, beta_max=255: beta 250->254->255->255->255, no wrap.
REQ-036 hold=1 for 3 cycles mid-sweep at position bit 2: update_out=0 those cycles, resumes at bit 2, done delayed exactly 3 cycles.
REQ-037 reset asserted mid-RUN at sweep 1 position bit 3: next cycle all outputs at reset values; start afterwards begins cleanly at bit 0.
REQ-038 n_sweeps=0 start: no update pulses, done next cycle; start asserted during RUN ignored (single done only).
REQ-039 With ANNEAL_SAMPLE_EN, n_sweeps=3: exactly 3 sample_valid pulses, each one cycle after a 10000 update.
